trigger_arbiter: RTL and testbench
==================================

Name: trigger_arbiter

Overview:
- Merges the three trigger sources (soft, IO, encoder) into one camera trigger output.
- Fixed priority selects between sources; each accepted trigger is stretched to a programmed pulse width.
- A programmed hold-off gap is enforced between triggers.
- Optionally one trigger arriving during a busy window is queued; the rest are dropped and counted for register readback.

Parameters:
- CNT_W, 32, width of accept/drop counters and of width/hold-off registers

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- reg_arb_en  input  1  global enable; low = abort and idle
- reg_src_en  input  3  per-source enable [0]=soft [1]=io [2]=encoder
- reg_trig_width  input  CNT_W  output pulse width in clk cycles; 0 treated as 1
- reg_trig_holdoff  input  CNT_W  idle cycles after pulse before next launch; 0 = none
- reg_pending_en  input  1  1 = queue one trigger while busy
- reg_cnt_clr  input  1  single-cycle clear of both counters
- soft_req  input  1  soft trigger request (level or pulse)
- io_req  input  1  IO trigger request
- enc_req  input  1  encoder trigger request
- trigger  output  1  merged, stretched trigger
- trigger_src  output  2  source of current pulse: 0 soft, 1 io, 2 encoder
- busy  output  1  high in PULSE or HOLDOFF
- pending  output  1  one trigger queued
- accept_cnt  output  CNT_W  triggers launched
- drop_cnt  output  CNT_W  requests discarded

Behaviour:
- Reset values: trigger=0, trigger_src=0, busy=0, pending=0, both counters=0, state=IDLE, edge registers=0.
- Request detect: req & ~req_d per source, where req_d is the value registered last cycle. A level held high yields one request. Masked by reg_src_en; masked edges are ignored and not counted.
- Priority: soft > io > encoder.
- FSM IDLE:
  - On any request edge at cycle N, go to PULSE.
  - trigger=1 and trigger_src=winner from cycle N+1.
  - accept_cnt increments.
- FSM PULSE:
  - trigger held for max(width,1) cycles.
  - Then go to HOLDOFF if holdoff>0, else launch/IDLE per the pending rule.
- FSM HOLDOFF:
  - trigger=0 for exactly holdoff cycles.
- End of busy (last PULSE cycle with holdoff=0, or last HOLDOFF cycle):
  - If pending=1, the next cycle enters PULSE with the queued source; pending clears; accept_cnt increments.
  - Otherwise go to IDLE.
- Busy edges (state PULSE/HOLDOFF, including the final cycle):
  - If reg_pending_en=1 and pending=0, queue the highest-priority edge.
  - All other edges: drop_cnt += 1 each.
- Simultaneous edges in IDLE:
  - Winner launches.
  - If reg_pending_en=1, the next-highest edge is queued.
  - Remaining edges are dropped, each counted.
- width/holdoff are sampled on entry to PULSE/HOLDOFF; changes mid-phase have no effect until the next entry.
- reg_arb_en=0 (synchronous):
  - State→IDLE, trigger=0 next cycle, pending cleared; no counting.
  - The queued trigger is discarded without counting.
  - Edge registers keep tracking while disabled.
- Disabling a source does not remove an already-queued trigger from that source.
- Counters saturate at all-ones. reg_cnt_clr has priority over a same-cycle increment.
- busy = (state != IDLE); registered.

Test Plan:
- width=4, holdoff=0, soft_req pulse at cycle 10 -> trigger high cycles 11-14, trigger_src=0, accept_cnt=1.
- width=3, holdoff=5, io edge at 10, enc edge at 12, pending_en=1:
  - trigger 11-13, holdoff 14-18, encoder pulse 19-21 with src=2.
  - accept_cnt=2, drop_cnt=0.
- Same as previous with pending_en=0 -> encoder dropped, drop_cnt=1, single pulse.
- All three edges same cycle 20, pending_en=1, width=2, holdoff=0:
  - soft pulse 21-22, io pulse 23-24.
  - encoder dropped, drop_cnt=1, accept_cnt=2.
- width=0, soft_req held high 50 cycles -> exactly one 1-cycle trigger, accept_cnt=1.
- Mid-pulse (width=10) deassert reg_arb_en at pulse cycle 3 with a trigger queued:
  - trigger low next cycle, pending=0, counters unchanged.
  - rst asserted asynchronously mid-pulse -> all outputs 0 immediately.

Source files
------------

// File: rtl/trigger_arbiter.sv
// Merges soft, IO and encoder trigger requests into one stretched camera trigger
// with fixed priority, hold-off spacing, a one-deep queue and saturating counters.
module trigger_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_arb_en,
  input  logic [2:0]       reg_src_en,
  input  logic [CNT_W-1:0] reg_trig_width,
  input  logic [CNT_W-1:0] reg_trig_holdoff,
  input  logic             reg_pending_en,
  input  logic             reg_cnt_clr,
  input  logic             soft_req,
  input  logic             io_req,
  input  logic             enc_req,
  output logic             trigger,
  output logic [1:0]       trigger_src,
  output logic             busy,
  output logic             pending,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLDOFF
  } state_t;

  state_t           state, state_n;
  logic [2:0]       req_d, edges, rest1, rest2;
  logic [1:0]       w1, w2;
  logic [1:0]       src, src_n;
  logic [1:0]       psrc, psrc_n, qs;
  logic             pend, pend_n, q;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] wload, hload;
  logic [CNT_W-1:0] acc, drop;
  logic [CNT_W:0]   dsum;
  logic             acc_inc;
  logic [1:0]       drops;

  function automatic logic [1:0] first(input logic [2:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [2:0] bit_of(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  function automatic logic [1:0] ones(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  assign edges = {enc_req, io_req, soft_req} & ~req_d & reg_src_en;
  assign w1    = first(edges);
  assign rest1 = edges & ~bit_of(w1);
  assign w2    = first(rest1);
  assign rest2 = rest1 & ~bit_of(w2);

  // cnt holds remaining cycles minus one, so a zero width still gives one cycle
  assign wload = (reg_trig_width == '0) ? '0 : reg_trig_width - CNT_W'(1);
  assign hload = reg_trig_holdoff - CNT_W'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    psrc_n  = psrc;
    src_n   = src;
    acc_inc = 1'b0;
    drops   = 2'd0;
    q       = pend;
    qs      = psrc;
    if (!reg_arb_en) begin
      state_n = IDLE;
      pend_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|edges) begin
            state_n = PULSE;
            cnt_n   = wload;
            src_n   = w1;
            acc_inc = 1'b1;
            if (reg_pending_en && |rest1) begin
              pend_n = 1'b1;
              psrc_n = w2;
              drops  = ones(rest2);
            end else begin
              drops = ones(rest1);
            end
          end
        end
        PULSE, HOLDOFF: begin
          if (|edges) begin
            if (reg_pending_en && !pend) begin
              q     = 1'b1;
              qs    = w1;
              drops = ones(rest1);
            end else begin
              drops = ones(edges);
            end
          end
          pend_n = q;
          psrc_n = qs;
          // an edge queued on the final busy cycle launches straight away
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (state == PULSE && reg_trig_holdoff != '0) begin
            state_n = HOLDOFF;
            cnt_n   = hload;
          end else if (q) begin
            state_n = PULSE;
            cnt_n   = wload;
            src_n   = qs;
            pend_n  = 1'b0;
            acc_inc = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign dsum = {1'b0, drop} + (CNT_W + 1)'(drops);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_d <= '0;
      pend  <= 1'b0;
      psrc  <= 2'd0;
      src   <= 2'd0;
      acc   <= '0;
      drop  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      req_d <= {enc_req, io_req, soft_req};
      pend  <= pend_n;
      psrc  <= psrc_n;
      src   <= src_n;
      if (reg_cnt_clr) begin
        acc  <= '0;
        drop <= '0;
      end else begin
        if (acc_inc && acc != '1) acc <= acc + CNT_W'(1);
        drop <= dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
      end
    end
  end

  assign trigger     = (state == PULSE);
  assign busy        = (state != IDLE);
  assign trigger_src = src;
  assign pending     = pend;
  assign accept_cnt  = acc;
  assign drop_cnt    = drop;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Scoreboard bench for trigger_arbiter: a time-window reference model predicts
// every cycle's outputs, a negedge monitor pops and compares.
module tb_trigger_arbiter;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reg_arb_en = 1'b0;
  logic [2:0]    reg_src_en = 3'b111;
  logic [CW-1:0] reg_trig_width = '0;
  logic [CW-1:0] reg_trig_holdoff = '0;
  logic          reg_pending_en = 1'b0;
  logic          reg_cnt_clr = 1'b0;
  logic          soft_req = 1'b0;
  logic          io_req = 1'b0;
  logic          enc_req = 1'b0;
  logic          trigger;
  logic [1:0]    trigger_src;
  logic          busy;
  logic          pending;
  logic [CW-1:0] accept_cnt;
  logic [CW-1:0] drop_cnt;

  trigger_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .reg_arb_en(reg_arb_en), .reg_src_en(reg_src_en),
    .reg_trig_width(reg_trig_width), .reg_trig_holdoff(reg_trig_holdoff),
    .reg_pending_en(reg_pending_en), .reg_cnt_clr(reg_cnt_clr),
    .soft_req(soft_req), .io_req(io_req), .enc_req(enc_req),
    .trigger(trigger), .trigger_src(trigger_src), .busy(busy),
    .pending(pending), .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          trig;
    logic [1:0]    src;
    logic          bsy;
    logic          pnd;
    logic [CW-1:0] acc;
    logic [CW-1:0] drp;
  } obs_t;

  typedef struct {
    int   t;
    obs_t o;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errs = 0;

  // configuration shadows, applied on the cycle they belong to
  logic          c_en = 1'b1;
  logic [2:0]    c_src = 3'b111;
  logic [CW-1:0] c_w = '0;
  logic [CW-1:0] c_h = '0;
  logic          c_pen = 1'b0;
  logic          c_clr = 1'b0;

  // reference model: launch time windows instead of a state machine
  bit         m_act, m_pend;
  int         m_pe, m_be;
  logic [1:0] m_src, m_psrc;
  int         m_acc, m_drop;
  logic [2:0] m_rd;

  function automatic logic [1:0] lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_act = 0; m_pend = 0; m_pe = 0; m_be = 0;
    m_src = 0; m_psrc = 0; m_acc = 0; m_drop = 0; m_rd = 0;
  endtask

  task automatic launch(input int k, input logic [1:0] s);
    int w;
    w = int'(reg_trig_width);
    if (w == 0) w = 1;
    m_act = 1;
    m_src = s;
    m_pe  = k + w;
    m_be  = m_pe;
  endtask

  task automatic model(input int k);
    logic [2:0] r, e, e2;
    int nd, inc;
    exp_t x;
    r = {enc_req, io_req, soft_req};
    e = r & ~m_rd & reg_src_en;
    m_rd = r;
    nd = 0;
    inc = 0;
    if (!reg_arb_en) begin
      m_act = 0;
      m_pend = 0;
    end else if (!m_act) begin
      if (e != 0) begin
        launch(k, lowest(e));
        inc = 1;
        e2 = e & ~(3'b001 << lowest(e));
        if (reg_pending_en && e2 != 0) begin
          m_pend = 1;
          m_psrc = lowest(e2);
          e2 = e2 & ~(3'b001 << m_psrc);
        end
        nd = $countones(e2);
      end
    end else begin
      if (e != 0) begin
        if (reg_pending_en && !m_pend) begin
          m_pend = 1;
          m_psrc = lowest(e);
          nd = $countones(e) - 1;
        end else begin
          nd = $countones(e);
        end
      end
      if (k == m_pe) m_be = m_pe + int'(reg_trig_holdoff);
      if (k == m_be) begin
        if (m_pend) begin
          launch(k, m_psrc);
          inc = 1;
          m_pend = 0;
        end else begin
          m_act = 0;
        end
      end
    end
    if (reg_cnt_clr) begin
      m_acc = 0;
      m_drop = 0;
    end else begin
      m_acc  = (m_acc + inc > MAXC) ? MAXC : m_acc + inc;
      m_drop = (m_drop + nd > MAXC) ? MAXC : m_drop + nd;
    end
    x.t = k + 1;
    x.o.trig = m_act && (k + 1 <= m_pe);
    x.o.src  = m_src;
    x.o.bsy  = m_act;
    x.o.pnd  = m_pend;
    x.o.acc  = CW'(m_acc);
    x.o.drp  = CW'(m_drop);
    sb.push_back(x);
  endtask

  task automatic step(input logic [2:0] r);
    @(posedge clk);
    #1;
    reg_arb_en       = c_en;
    reg_src_en       = c_src;
    reg_trig_width   = c_w;
    reg_trig_holdoff = c_h;
    reg_pending_en   = c_pen;
    reg_cnt_clr      = c_clr;
    c_clr            = 1'b0;
    {enc_req, io_req, soft_req} = r;
    model(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000);
  endtask

  task automatic check_zero(input string name);
    obs_t a;
    a = {trigger, trigger_src, busy, pending, accept_cnt, drop_cnt};
    vectors++;
    if (a !== '0) begin
      errs++;
      $display("FAIL %s: outputs=%h required 0", name, a);
    end
  endtask

  always @(negedge clk) begin
    obs_t a;
    exp_t x;
    a = {trigger, trigger_src, busy, pending, accept_cnt, drop_cnt};
    while (sb.size() > 0 && sb[0].t < cyc) begin
      x = sb.pop_front();
      vectors++;
      errs++;
      $display("FAIL stale cycle %0d: expectation never compared", x.t);
    end
    if (sb.size() > 0 && sb[0].t == cyc) begin
      x = sb.pop_front();
      vectors++;
      if (a !== x.o) begin
        errs++;
        $display("FAIL cycle %0d: trig/src/busy/pend/acc/drop = %b/%0d/%b/%b/%0d/%0d required %b/%0d/%b/%b/%0d/%0d",
                 cyc, a.trig, a.src, a.bsy, a.pnd, a.acc, a.drp,
                 x.o.trig, x.o.src, x.o.bsy, x.o.pnd, x.o.acc, x.o.drp);
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // single soft pulse, width 4
    c_w = 4; c_h = 0; c_pen = 0; c_clr = 1;
    idle(2);
    step(3'b001); idle(8);

    // io then encoder during busy, queued
    c_w = 3; c_h = 5; c_pen = 1; c_clr = 1;
    idle(2);
    step(3'b010); step(3'b000); step(3'b100); idle(16);

    // same with queueing off: encoder dropped
    c_pen = 0; c_clr = 1;
    idle(2);
    step(3'b010); step(3'b000); step(3'b100); idle(12);

    // three simultaneous edges
    c_w = 2; c_h = 0; c_pen = 1; c_clr = 1;
    idle(2);
    step(3'b111); idle(8);

    // zero width, level held
    c_w = 0; c_clr = 1;
    idle(2);
    for (int i = 0; i < 50; i++) step(3'b001);
    idle(4);

    // abort mid-pulse with a queued trigger
    c_w = 10; c_pen = 1; c_clr = 1;
    idle(2);
    step(3'b001); step(3'b010); step(3'b000);
    c_en = 0;
    step(3'b000);
    c_en = 1;
    idle(6);

    // async reset mid-pulse
    c_w = 10; c_pen = 0;
    step(3'b001); step(3'b000); step(3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    sb.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // randomized traffic with occasional config changes
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] r;
      if ($urandom_range(0, 39) == 0) begin
        c_w   = CW'($urandom_range(0, 5));
        c_h   = CW'($urandom_range(0, 4));
        c_pen = 1'($urandom_range(0, 1));
        c_src = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
        c_en  = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 399) == 0) c_clr = 1'b1;
      for (int b = 0; b < 3; b++) r[b] = ($urandom_range(0, 3) == 0);
      step(r);
    end
    c_en = 1;
    idle(20);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() > 1) begin
      vectors++;
      errs++;
      $display("FAIL drain: %0d expectations left, required at most 1", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
